// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions used by the instruction fetch stage.
// Optional feature macro: IFU_MISALIGN_CHECK_EN adds the FAULT state.
package rv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        FAULT
`endif
    } ifu_state_t;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam int          INST_BYTES = 4;

endpackage : rv_pkg

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel,
// decode valid/ready handshake and the execute redirect port.
// Optional feature macro: IFU_MISALIGN_CHECK_EN adds fault_o.
interface inst_fetch_if;

    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
`ifdef IFU_MISALIGN_CHECK_EN
    logic        fault_o;
`endif

    // Fetch unit side.
    modport master (
`ifdef IFU_MISALIGN_CHECK_EN
        output fault_o,
`endif
        output imem_req_valid_o, imem_req_addr_o, valid_o, inst_o, pc_o,
        input  imem_req_ready_i, imem_resp_valid_i, imem_resp_data_i,
        input  redirect_i, redirect_pc_i, ready_i
    );

    // Memory / decode / execute side.
    modport slave (
`ifdef IFU_MISALIGN_CHECK_EN
        input  fault_o,
`endif
        input  imem_req_valid_o, imem_req_addr_o, valid_o, inst_o, pc_o,
        output imem_req_ready_i, imem_resp_valid_i, imem_resp_data_i,
        output redirect_i, redirect_pc_i, ready_i
    );

endinterface : inst_fetch_if

// File: rtl/ifu_pc_gen.sv
// Next-PC generator: redirect target has priority over sequential advance.
// Optional feature macro: IFU_MISALIGN_CHECK_EN keeps the raw target and
// flags misalignment; otherwise the target is word-aligned by masking.
module ifu_pc_gen
    import rv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
`ifdef IFU_MISALIGN_CHECK_EN
    output logic        misaligned,
`endif
    output logic [31:0] pc_next
);

    logic [31:0] target;

`ifdef IFU_MISALIGN_CHECK_EN
    assign target     = redirect_pc;
    assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);
`else
    assign target     = {redirect_pc[31:2], 2'b00};
`endif

    // Redirect wins over a simultaneous decode handshake; PC wraps modulo 2^32.
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = target;
        end else if (advance) begin
            pc_next = pc + 32'(INST_BYTES);
        end
    end

endmodule : ifu_pc_gen

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding word fetch, registered
// {pc_o, inst_o} to decode, redirect handling with stale-response kill.
// Optional feature macro: IFU_MISALIGN_CHECK_EN (misaligned redirect trap).
module inst_fetch
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);

    ifu_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        advance;
`ifdef IFU_MISALIGN_CHECK_EN
    logic        misaligned;
`endif

    assign advance = (state_q == HOLD) && bus.ready_i;

    ifu_pc_gen u_pc_gen (
        .pc          (pc_q),
        .redirect    (bus.redirect_i),
        .redirect_pc (bus.redirect_pc_i),
        .advance     (advance),
`ifdef IFU_MISALIGN_CHECK_EN
        .misaligned  (misaligned),
`endif
        .pc_next     (pc_d)
    );

    // Next-state and datapath-capture decode for the fetch FSM.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        kill_d   = kill_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (bus.imem_req_ready_i) begin
                    // The old address is already accepted; its reply must be discarded.
                    state_d = WAIT;
                    kill_d  = bus.redirect_i;
                end
            end
            WAIT: begin
                if (bus.imem_resp_valid_i) begin
                    if (kill_q || bus.redirect_i) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d   = bus.imem_resp_data_i;
                        pc_out_d = pc_q;
                        state_d  = HOLD;
                    end
                end else if (bus.redirect_i) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (bus.redirect_i || bus.ready_i) begin
                    state_d = REQ;
                end
            end
`ifdef IFU_MISALIGN_CHECK_EN
            FAULT: begin
                if (bus.redirect_i && !misaligned) begin
                    state_d = REQ;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
`ifdef IFU_MISALIGN_CHECK_EN
        // A misaligned target traps from any state and reports the bad PC.
        if (misaligned) begin
            state_d  = FAULT;
            kill_d   = 1'b0;
            pc_out_d = bus.redirect_pc_i;
        end
`endif
    end

    // State, PC and decode-facing registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            kill_q   <= 1'b0;
            inst_q   <= NOP_INST;
            pc_out_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            kill_q   <= kill_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
        end
    end

    assign bus.imem_req_valid_o = (state_q == REQ);
    assign bus.imem_req_addr_o  = pc_q;
    assign bus.valid_o          = (state_q == HOLD);
    assign bus.inst_o           = inst_q;
    assign bus.pc_o             = pc_out_q;
`ifdef IFU_MISALIGN_CHECK_EN
    assign bus.fault_o          = (state_q == FAULT);
`endif

endmodule : inst_fetch

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the RISC-V core, directly upstream of the decoder. Holds the PC, issues one word-fetch at a time to instruction memory over a valid/ready request plus response-valid channel, and presents `{pc_o, inst_o}` to decode with a valid/ready handshake. Accepts PC redirects from execute (taken branch, `jal`/`jalr`) and discards any in-flight fetch made stale by a redirect.

## Interface
- `RESET_PC`, default `32'h8000_0000`: PC loaded on reset.
- `clk` input 1: the single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `imem_req_valid_o` output 1: fetch request valid.
- `imem_req_addr_o` output 32: fetch address, always the registered PC.
- `imem_req_ready_i` input 1: memory accepts the request this cycle.
- `imem_resp_valid_i` input 1: `imem_resp_data_i` valid this cycle. Memory has no backpressure.
- `imem_resp_data_i` input 32: fetched instruction word.
- `redirect_i` input 1: load `redirect_pc_i` as the next fetch PC.
- `redirect_pc_i` input 32: redirect target.
- `valid_o` output 1: `inst_o` and `pc_o` valid for decode.
- `ready_i` input 1: decode consumes this cycle.
- `inst_o` output 32: instruction to decode. Registered.
- `pc_o` output 32: PC of `inst_o`. Registered.
- `fault_o` output 1: misaligned redirect trap. Present only with `IFU_MISALIGN_CHECK_EN`.

## Operation
- FSM states: `IDLE`, `REQ`, `WAIT`, `HOLD`, plus `FAULT` (macro only). At most one request is outstanding.
- `IDLE`: entered on reset, lasts one cycle, then goes to `REQ`.
- `REQ`: `imem_req_valid_o=1`, addr = pc. On `imem_req_ready_i`, go to `WAIT`.
- `WAIT`: on `imem_resp_valid_i` with kill clear, latch `inst_o=data`, `pc_o=pc`, and go to `HOLD`.
- `HOLD`: `valid_o=1`. On `ready_i`, set pc ← pc+4 and go to `REQ`. While `ready_i=0`, `inst_o` and `pc_o` stay stable.
- PC arithmetic is 32-bit modulo; `32'hFFFF_FFFC`+4 wraps to `0`.
- Redirect (`redirect_i=1`) sets pc ← `redirect_pc_i` in every state. Per-state behaviour:
  - `IDLE`: continue to `REQ` with the new pc.
  - `REQ` without `imem_req_ready_i`: stay in `REQ`; the new address appears next cycle.
  - `REQ` with `imem_req_ready_i` in the same cycle: the old address is accepted; go to `WAIT` with `kill=1`.
  - `WAIT` without response: set `kill=1`.
  - `WAIT` with response in the same cycle: drop the response and go to `REQ`.
  - `HOLD`: `valid_o` drops next cycle and the FSM goes to `REQ`. Redirect wins over a simultaneous `ready_i` handshake: the instruction counts as consumed and pc = target, not pc+4.
- `kill`: in `WAIT`, a response arriving with `kill=1` is dropped, `kill` clears, and the FSM goes to `REQ`.
- Reset mid-operation returns the FSM to `IDLE`. A memory response arriving in the cycle after reset is ignored because the FSM is not in `WAIT`. The memory side must drop its own outstanding request on the same `rst`.

## Timing
- Reset values: `imem_req_valid_o=0`, `imem_req_addr_o=RESET_PC`, `valid_o=0`, `inst_o=32'h0000_0013` (nop), `pc_o=RESET_PC`, `fault_o=0`, `kill=0`.
- First request is in the 2nd cycle after `rst` deasserts.
- Request accepted in cycle N, response in cycle N+k → `valid_o` high in cycle N+k+1.
- Decode handshake in cycle M → next request in cycle M+1.
- Best throughput with k=1 and `ready_i` always high: one instruction every 3 cycles.
- Redirect in cycle R → new address on `imem_req_addr_o` from R+1. The exception is `WAIT` with no response yet: the new address is issued in the cycle after the stale response is dropped.
- No combinational path from `ready_i` or `redirect_i` to any output. All outputs are registered or decoded from FSM state only.

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc_i[1:0]!=0` goes to `FAULT`, with `pc_o` = target and `fault_o=1` from the next cycle.
  - No request is issued in `FAULT`, and `valid_o=0`.
  - `FAULT` exits only on a subsequent aligned redirect (to `REQ`) or on `rst`.
- `IFU_MISALIGN_CHECK_EN` undefined: the target is used with bits `[1:0]` forced to `0`, and the `fault_o` port does not exist.

## Structure
- Shared package `rv_pkg` holds:
  - the FSM state enum `ifu_state_t`;
  - `NOP_INST = 32'h0000_0013`;
  - `INST_BYTES = 4`.
- Optional sub-module `ifu_pc_gen`: computes next pc from pc, redirect, and the aligned/misaligned decision. All other logic stays in `inst_fetch`.

## Test plan
- Reset release, memory returns in 1 cycle, `ready_i=1` → requests to `80000000`, `80000004`, `80000008` at cycles 2, 5, 8; matching `pc_o` values on `valid_o`.
- `ready_i=0` for 5 cycles in `HOLD` → `inst_o`/`pc_o` stable, no new request, `imem_req_valid_o=0`.
- Redirect to `80000100` while in `WAIT`; stale response `deadbeef` 3 cycles later → stale word never on `valid_o`; next request addr `80000100`.
- Redirect and response in the same cycle, and separately redirect and `ready_i` in the same cycle in `HOLD` → next request is the target, never pc+4.
- Redirect to `80000102`:
  - with macro: `fault_o=1`, `pc_o=80000102`, no request; a later redirect to `80000200` resumes fetching.
  - without macro: request to `80000100`.
- `rst` asserted in `WAIT`, then a response arrives the cycle after → ignored; fetch restarts at `80000000`. Separately, starting from pc `FFFFFFFC` (via redirect) → next request `00000000`.
